// File: rtl/mux_2to1_rr_pkg.sv
// Shared widths and lane-order constants for the 2-lane demux/merge pair.
package mux_2to1_rr_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    // Lane order: the demux sends lane 0 first, so the merge starts there too.
    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  count_t;

endpackage

// File: rtl/mux_2to1_rr_if.sv
// Two valid-qualified input lanes, merged output stream and FIFO status.
interface mux_2to1_rr_if;
    import mux_2to1_rr_pkg::*;

    logic  valid_in0;
    word_t data_in0;
    logic  valid_in1;
    word_t data_in1;
    logic  valid_out;
    word_t data_out;
    logic  full0;
    logic  full1;
    logic  overflow;

    modport master (
        output valid_in0, data_in0, valid_in1, data_in1,
        input  valid_out, data_out, full0, full1, overflow
    );

    modport slave (
        input  valid_in0, data_in0, valid_in1, data_in1,
        output valid_out, data_out, full0, full1, overflow
    );

endinterface

// File: rtl/mux_2to1_rr_lane_fifo.sv
// Per-lane synchronous FIFO; a write into a full FIFO is accepted only when
// the same edge pops, otherwise it is dropped and flagged for one cycle.
module mux_2to1_rr_lane_fifo
    import mux_2to1_rr_pkg::*;
#(
    parameter int unsigned W  = DATA_W,
    parameter int unsigned D  = DEPTH,
    parameter int unsigned AW = ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_req,
    input  logic [W-1:0]    din,
    input  logic            pop,
    output logic [W-1:0]    dout,
    output logic [AW:0]     count,
    output logic            full,
    output logic            ovf
);

    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          pop_ok;
    logic          push;

    // Accept/drop decision uses occupancy before this edge.
    always_comb begin
        empty  = (count == '0);
        full   = (count == CW'(D));
        pop_ok = pop && !empty;
        push   = push_req && (!full || pop_ok);
        ovf    = push_req && full && !pop_ok;
        dout   = mem[rd_ptr];
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo D; count tracks net occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/mux_2to1_rr.sv
// Round-robin merge of two lanes back into one ordered stream; stalls on the
// lane whose turn it is rather than ever popping out of order.
module mux_2to1_rr
    import mux_2to1_rr_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mux_2to1_rr_if.slave  bus
);

    lane_e  lane_q;
    lane_e  lane_d;
    logic   pop0;
    logic   pop1;
    logic   valid_d;
    word_t  data_d;
    word_t  head0;
    word_t  head1;
    count_t count0;
    count_t count1;
    logic   full0;
    logic   full1;
    logic   ovf0;
    logic   ovf1;
    logic   valid_q;
    word_t  data_q;
    logic   overflow_q;

    mux_2to1_rr_lane_fifo u_fifo0 (
        .clk      (clk),
        .reset    (reset),
        .push_req (bus.valid_in0),
        .din      (bus.data_in0),
        .pop      (pop0),
        .dout     (head0),
        .count    (count0),
        .full     (full0),
        .ovf      (ovf0)
    );

    mux_2to1_rr_lane_fifo u_fifo1 (
        .clk      (clk),
        .reset    (reset),
        .push_req (bus.valid_in1),
        .din      (bus.data_in1),
        .pop      (pop1),
        .dout     (head1),
        .count    (count1),
        .full     (full1),
        .ovf      (ovf1)
    );

    // Arbiter next-state and pop selection: only the current lane may pop.
    always_comb begin
        lane_d  = lane_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        valid_d = 1'b0;
        data_d  = data_q;
        case (lane_q)
            LANE0: begin
                if (count0 != '0) begin
                    pop0    = 1'b1;
                    valid_d = 1'b1;
                    data_d  = head0;
                    lane_d  = LANE1;
                end
            end
            LANE1: begin
                if (count1 != '0) begin
                    pop1    = 1'b1;
                    valid_d = 1'b1;
                    data_d  = head1;
                    lane_d  = LANE0;
                end
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= LANE0;
        end else begin
            lane_q <= lane_d;
        end
    end

    // Output word register and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_q | ovf0 | ovf1;
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.full0     = full0;
    assign bus.full1     = full1;
    assign bus.overflow  = overflow_q;

endmodule

// File: doc/mux_2to1_rr.md
Name: mux_2to1_rr

Overview:
- Merge side of the 1-to-2 demux: recombines two 4-bit valid-qualified lanes into one stream.
- The demux distributes words alternately, lane 0 first. This block restores that order with strict round-robin: lane 0, lane 1, lane 0, ...
- Each lane has a small FIFO to absorb skew between the lanes.
- Sits downstream of the demux and any per-lane processing, at the single-stream output of the datapath.

Parameters:
- DATA_W, 4, width of every data word
- DEPTH, 4, entries per lane FIFO; must be a power of two, >= 2
- ADDR_W, 2, log2(DEPTH); FIFO pointer width

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- valid_in0  input  1  lane 0 word valid
- data_in0  input  DATA_W  lane 0 word
- valid_in1  input  1  lane 1 word valid
- data_in1  input  DATA_W  lane 1 word
- valid_out  output  1  merged word valid, registered
- data_out  output  DATA_W  merged word, registered
- full0  output  1  lane 0 FIFO holds DEPTH entries
- full1  output  1  lane 1 FIFO holds DEPTH entries
- overflow  output  1  sticky: a word was dropped on some lane

Behaviour:
- Reset, while reset=1 at a rising edge:
  - both FIFOs emptied (pointers and counts = 0)
  - next_lane = 0
  - valid_out = 0, data_out = 0, overflow = 0
  - full0 = full1 = 0 after the edge
  - reset mid-stream discards all buffered words; no partial output.
- Write: on each edge, valid_inX=1 pushes data_inX into FIFO X. Invalid cycles push nothing; data_inX is don't-care.
- Arbiter state: one bit, next_lane. States are LANE0 and LANE1.
- Pop, on each edge:
  - FIFO[next_lane] non-empty (count before this edge's write): pop its head into data_out, set valid_out=1, toggle next_lane.
  - FIFO[next_lane] empty: valid_out=0, data_out holds its previous value, next_lane unchanged.
  - The other lane is never popped out of turn, even if non-empty. Order is guaranteed at the cost of stalling.
- Latency: a word written at edge N is popped no earlier than edge N+1, so valid_out is first seen 2 cycles after the input cycle. No same-cycle bypass.
- Full FIFO:
  - write while full with no pop that edge: word dropped, overflow set to 1 and held until reset.
  - write while full with a pop that edge: accepted, count unchanged.
- Empty FIFO: write and "no pop" are legal; never underflows.
- Pointer wrap-around: read/write pointers are ADDR_W bits and wrap modulo DEPTH. count is ADDR_W+1 bits, range 0..DEPTH.
- fullX is combinational from countX == DEPTH; reflects state after the last edge.
- Simultaneous valid on both lanes: both words written the same edge. Output emits them on consecutive cycles, lane 0 first if next_lane=0.

Decomposition:
- Shared package: DATA_W, DEPTH, ADDR_W defaults; LANE0/LANE1 state constants. Shared with the demux so the lane order matches.
- One sub-module, lane_fifo: synchronous single-clock FIFO with push, pop, data in/out, count, full, empty, and per-lane overflow pulse. Instantiated twice.
- The top holds the arbiter bit, output register and sticky overflow OR.

Test Plan:
- Reset, then one cycle with lane 0 = 0xA, lane 1 = 0xF, both valid -> valid_out=1 with 0xA 2 cycles later, then 0xF the next cycle, then valid_out=0.
- Lane 1 = 0x3 valid alone, lane 0 idle for 5 cycles, then lane 0 = 0x2 -> valid_out stays 0 throughout the idle period. Then 0x2 followed by 0x3 on consecutive cycles.
- Lane 0 writes 0x1..0x6 on 6 consecutive edges, lane 1 idle, DEPTH=4:
  - 0x1 emitted
  - full0=1 after the 5th write
  - 0x6 dropped, overflow=1 and stays 1
  - lane 1 then sends 0xB -> output 0xB, then 0x2, 0x3, 0x4, 0x5 alternating only as lane 1 supplies words.
- Continuous alternating input (lane 0: 0x0,0x2,0x4,...; lane 1: 0x1,0x3,0x5,...) for 12 cycles -> output 0x0,0x1,0x2,...,0xB in order, with no gaps after the first word. FIFOs wrap without loss and overflow stays 0.
- Reset asserted for 1 cycle while both FIFOs hold 2 words -> next edge valid_out=0, full0=full1=0, overflow=0. New words 0x7 (lane 0) and 0x8 (lane 1) emerge as 0x7 then 0x8.
- Pop and write on the same edge while full0=1 -> word accepted, full0 remains 1, overflow unchanged.
